rx_mass_checker: RTL and testbench



---
 rtl/rx_mass_pkg.sv | 33 +++
 rtl/rx_mass_report_ser.sv | 74 +++++++
 rtl/rx_mass_checker.sv | 164 ++++++++++++++++
 tb/tb_rx_mass_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_mass_pkg.sv
// Shared constants and helpers for the RX mass-transfer checker.
// Optional macro RX_MASS_TIMEOUT_EN adds an idle timeout and a status byte.
package rx_mass_pkg;

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;

`ifdef RX_MASS_TIMEOUT_EN
  localparam int REPORT_LEN = 9;
`else
  localparam int REPORT_LEN = 8;
`endif

  localparam int RPT_W = 8 * REPORT_LEN;

  localparam logic [31:0] NO_ERR_IDX = 32'hFFFF_FFFF;

  localparam logic [7:0] STATUS_OK      = 8'h00;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h01;

  function automatic logic [31:0] set_byte(
    input logic [31:0] w,
    input logic [1:0]  k,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    r[8*k +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/rx_mass_report_ser.sv
// Serialises a report vector LSB byte first onto an AXI-stream
// with valid/ready/last; done marks the final handshake cycle.
import rx_mass_pkg::*;

module rx_mass_report_ser (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [RPT_W-1:0] rpt,
  input  logic             o_tready,
  output logic             o_tvalid,
  output logic [7:0]       o_tdata,
  output logic             o_tlast,
  output logic             done
);

  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [7:0]       data_q, data_d;
  logic [RPT_W-1:0] sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             hs;

  // next byte selection: load on start, advance on handshake
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    hs      = valid_q & o_tready;
    if (start) begin
      valid_d = 1'b1;
      last_d  = 1'b0;
      data_d  = rpt[7:0];
      sr_d    = rpt >> 8;
      cnt_d   = 4'd0;
    end else if (hs) begin
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        cnt_d   = 4'd0;
      end else begin
        data_d = sr_q[7:0];
        sr_d   = sr_q >> 8;
        cnt_d  = cnt_q + 4'd1;
        last_d = (cnt_q == 4'(REPORT_LEN - 2));
      end
    end
  end

  // output and shift registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= 8'h00;
      sr_q    <= '0;
      cnt_q   <= 4'd0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_tvalid = valid_q;
  assign o_tdata  = data_q;
  assign o_tlast  = last_q;
  assign done     = hs & last_q;

endmodule

// File: rtl/rx_mass_checker.sv
// Checks a host-to-FPGA length-prefixed incrementing-byte transfer
// and returns an error report. Option: RX_MASS_TIMEOUT_EN.
import rx_mass_pkg::*;

module rx_mass_checker #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd60000000
) (
  input  logic       clk,
  input  logic       rstn,
  output logic       i_tready,
  input  logic       i_tvalid,
  input  logic [7:0] i_tdata,
  input  logic       o_tready,
  output logic       o_tvalid,
  output logic [7:0] o_tdata,
  output logic       o_tlast
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       hdr_cnt_q, hdr_cnt_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      idx_q, idx_d;
  logic [31:0]      err_cnt_q, err_cnt_d;
  logic [31:0]      first_err_q, first_err_d;
  logic             start_q, start_d;
  logic             beat;
  logic             done;
  logic [RPT_W-1:0] rpt;

`ifdef RX_MASS_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic [7:0]  status_q, status_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign i_tready = (state_q != S_REPORT);
  assign beat     = i_tvalid & i_tready;

  // header assembly, payload checking and report handoff
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    len_d       = len_q;
    idx_d       = idx_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    start_d     = 1'b0;
`ifdef RX_MASS_TIMEOUT_EN
    idle_d      = idle_q;
    status_d    = status_q;
`endif
    unique case (1'b1)
      (state_q == S_HDR): begin
        if (beat) begin
          len_d     = set_byte(len_q, hdr_cnt_q, i_tdata);
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            idx_d = 32'd0;
            if (len_d == 32'd0) begin
              state_d = S_REPORT;
              start_d = 1'b1;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
      end
      (state_q == S_PAYLOAD): begin
        if (beat) begin
          if (i_tdata != idx_q[7:0]) begin
            err_cnt_d = err_cnt_q + 32'd1;
            if (first_err_q == NO_ERR_IDX)
              first_err_d = idx_q;
          end
          idx_d = idx_q + 32'd1;
          if (idx_q == len_q - 32'd1) begin
            state_d = S_REPORT;
            start_d = 1'b1;
          end
`ifdef RX_MASS_TIMEOUT_EN
          idle_d = 32'd0;
        end else if (idle_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d  = S_REPORT;
          start_d  = 1'b1;
          status_d = STATUS_TIMEOUT;
          idle_d   = 32'd0;
        end else begin
          idle_d = idle_q + 32'd1;
`endif
        end
      end
      (state_q == S_REPORT): begin
        if (done) begin
          state_d     = S_HDR;
          hdr_cnt_d   = 2'd0;
          len_d       = 32'd0;
          idx_d       = 32'd0;
          err_cnt_d   = 32'd0;
          first_err_d = NO_ERR_IDX;
`ifdef RX_MASS_TIMEOUT_EN
          idle_d      = 32'd0;
          status_d    = STATUS_OK;
`endif
        end
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  // checker state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_HDR;
      hdr_cnt_q   <= 2'd0;
      len_q       <= 32'd0;
      idx_q       <= 32'd0;
      err_cnt_q   <= 32'd0;
      first_err_q <= NO_ERR_IDX;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      start_q     <= start_d;
    end
  end

`ifdef RX_MASS_TIMEOUT_EN
  // idle counter and completion status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_q   <= 32'd0;
      status_q <= STATUS_OK;
    end else begin
      idle_q   <= idle_d;
      status_q <= status_d;
    end
  end

  assign rpt = {status_q, first_err_q, err_cnt_q};
`else
  assign rpt = {first_err_q, err_cnt_q};
`endif

  rx_mass_report_ser u_ser (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start_q),
    .rpt      (rpt),
    .o_tready (o_tready),
    .o_tvalid (o_tvalid),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .done     (done)
  );

endmodule

// File: tb/tb_rx_mass_checker.sv
// Directed bench for rx_mass_checker with a report model and
// per-cycle output checker. Honors RX_MASS_TIMEOUT_EN.
module tb_rx_mass_checker;

`ifdef RX_MASS_TIMEOUT_EN
  localparam int RL = 9;
`else
  localparam int RL = 8;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_tvalid = 1'b0;
  logic [7:0] i_tdata = 8'h00;
  logic       o_tready = 1'b1;
  logic       i_tready;
  logic       o_tvalid;
  logic [7:0] o_tdata;
  logic       o_tlast;

  int checks = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay[$];
  bit rand_rdy = 1'b0;
  bit rand_gap = 1'b0;

  always #5 clk = ~clk;

  rx_mass_checker #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_tready (i_tready),
    .i_tvalid (i_tvalid),
    .i_tdata  (i_tdata),
    .o_tready (o_tready),
    .o_tvalid (o_tvalid),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // push an expected report: err count, first error index, status
  task automatic push_lit(input logic [31:0] err, input logic [31:0] fe,
                          input logic [7:0] st);
    for (int k = 0; k < 4; k++) exp_q.push_back(err[8*k +: 8]);
    for (int k = 0; k < 4; k++) exp_q.push_back(fe[8*k +: 8]);
    if (RL == 9) exp_q.push_back(st);
  endtask

  // model: derive report from the payload held in pay
  task automatic push_model();
    logic [31:0] err;
    logic [31:0] fe;
    err = 0;
    fe = 32'hFFFF_FFFF;
    for (int i = 0; i < pay.size(); i++) begin
      if (pay[i] != 8'(i)) begin
        err++;
        if (fe == 32'hFFFF_FFFF) fe = i;
      end
    end
    push_lit(err, fe, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit rdy;
    if (rand_gap) begin
      i_tvalid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    i_tvalid = 1'b1;
    i_tdata = b;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = i_tready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 2000) begin
        checks++;
        fails++;
        $display("FAIL beat_timeout: byte %0h not accepted", b);
        break;
      end
    end
    i_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] len);
    for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8]);
  endtask

  task automatic send_pay();
    for (int i = 0; i < pay.size(); i++) send_byte(pay[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d report bytes missing", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // output ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // compare process: stability, back-pressure, report bytes
  initial begin
    logic       pv;
    logic       pr;
    logic       pl;
    logic [7:0] pd;
    logic [7:0] e;
    int         ri;
    pv = 0; pr = 0; pl = 0; pd = 0; ri = 0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (pv && !pr) begin
          chk("hold_valid", o_tvalid, 1);
          chk("hold_data", o_tdata, pd);
          chk("hold_last", o_tlast, pl);
        end
        if (o_tvalid) chk("rx_backpressure", i_tready, 0);
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL extra_byte: got %0h expected none", o_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("rpt_byte", o_tdata, e);
            chk("rpt_last", o_tlast, (ri == RL - 1));
            ri = (ri == RL - 1) ? 0 : ri + 1;
          end
        end
        pv = o_tvalid; pr = o_tready; pd = o_tdata; pl = o_tlast;
      end else begin
        pv = 0;
        ri = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_tlast", o_tlast, 0);
    chk("rst_itready", i_tready, 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // len 4, clean payload
    push_lit(32'd0, 32'hFFFF_FFFF, 8'h00);
    send_hdr(32'd4);
    pay = '{8'h00, 8'h01, 8'h02, 8'h03};
    send_pay();
    drain();

    // len 300, one corrupt byte at index 257
    push_lit(32'd1, 32'd257, 8'h00);
    send_hdr(32'd300);
    for (int i = 0; i < 300; i++)
      send_byte(i == 257 ? 8'hAA : 8'(i));
    drain();

    // zero length goes straight to the report
    push_lit(32'd0, 32'hFFFF_FFFF, 8'h00);
    send_hdr(32'd0);
    drain();
    chk("itready_after_rpt", i_tready, 1);

    // len 1, wrong byte at index 0
    push_lit(32'd1, 32'd0, 8'h00);
    send_hdr(32'd1);
    send_byte(8'h07);
    drain();

    // random gaps and stalls, two back-to-back transfers
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    pay = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    push_model();
    send_hdr(32'd8);
    send_pay();
    pay[5] = 8'h55;
    pay[6] = 8'h66;
    push_model();
    send_hdr(32'd8);
    send_pay();
    drain();
    rand_rdy = 1'b0;
    rand_gap = 1'b0;
    @(posedge clk);
    #1;

    // asynchronous reset mid-payload
    send_hdr(32'd16);
    send_byte(8'h00);
    send_byte(8'h01);
    #3;
    rstn = 1'b0;
    #1;
    chk("mid_rst_tvalid", o_tvalid, 0);
    chk("mid_rst_tdata", o_tdata, 0);
    chk("mid_rst_tlast", o_tlast, 0);
    chk("mid_rst_itready", i_tready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push_lit(32'd0, 32'hFFFF_FFFF, 8'h00);
    send_hdr(32'd2);
    send_byte(8'h00);
    send_byte(8'h01);
    drain();

`ifdef RX_MASS_TIMEOUT_EN
    // stalled payload times out after 100 idle cycles
    push_lit(32'd0, 32'hFFFF_FFFF, 8'h01);
    send_hdr(32'd10);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (90) @(posedge clk);
    #1;
    chk("no_early_timeout", o_tvalid, 0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
